// File: rtl/trn_rx_bar_decoder_if.sv
// Signal bundle between the TRN receive side of the PCIe endpoint and the BAR decoder,
// including the register-write strobe and the held read-request handshake.
interface trn_rx_bar_decoder_if #(
   parameter int ADDR_WIDTH = 12
) ();
   logic                  trn_lnk_up_n;
   logic [63:0]           trn_rd;
   logic                  trn_rrem_n;
   logic                  trn_rsof_n;
   logic                  trn_reof_n;
   logic                  trn_rsrc_rdy_n;
   logic                  trn_rsrc_dsc_n;
   logic [6:0]            trn_rbar_hit_n;
   logic                  trn_rdst_rdy_n;
   logic                  trn_rnp_ok_n;
   logic                  wr_en;
   logic [ADDR_WIDTH-3:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            wr_be;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [ADDR_WIDTH-3:0] rd_addr;
   logic [3:0]            rd_be;
   logic [7:0]            rd_tag;
   logic [15:0]           rd_req_id;
   logic [2:0]            rd_tc;
   logic [1:0]            rd_attr;
   logic [15:0]           drop_cnt;

   modport master (
      output trn_lnk_up_n, trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
             trn_rsrc_dsc_n, trn_rbar_hit_n, rd_ready,
      input  trn_rdst_rdy_n, trn_rnp_ok_n, wr_en, wr_addr, wr_data, wr_be, rd_valid,
             rd_addr, rd_be, rd_tag, rd_req_id, rd_tc, rd_attr, drop_cnt
   );

   modport slave (
      input  trn_lnk_up_n, trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
             trn_rsrc_dsc_n, trn_rbar_hit_n, rd_ready,
      output trn_rdst_rdy_n, trn_rnp_ok_n, wr_en, wr_addr, wr_data, wr_be, rd_valid,
             rd_addr, rd_be, rd_tag, rd_req_id, rd_tc, rd_attr, drop_cnt
   );
endinterface

// File: rtl/trn_rx_bar_decoder.sv
// Decodes single-DW MWr32/MRd32 TLPs hitting one BAR from the 64-bit TRN Rx stream into
// register write strobes and held read requests; every other TLP is dropped and counted.
module trn_rx_bar_decoder #(
   parameter int BAR_INDEX  = 0,
   parameter int ADDR_WIDTH = 12
) (
   input logic                 trn_clk,
   input logic                 trn_reset_n,
   trn_rx_bar_decoder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_HDR2, S_DISCARD} state_t;

   state_t                r_state;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-3:0] r_wr_addr;
   logic [31:0]           r_wr_data;
   logic [3:0]            r_wr_be;
   logic                  r_rd_valid;
   logic [ADDR_WIDTH-3:0] r_rd_addr;
   logic [3:0]            r_rd_be;
   logic [7:0]            r_rd_tag;
   logic [15:0]           r_rd_req_id;
   logic [2:0]            r_rd_tc;
   logic [1:0]            r_rd_attr;
   logic [15:0]           r_drop_cnt;
   logic                  r_hdr_wr;
   logic [3:0]            r_hdr_be;
   logic [7:0]            r_hdr_tag;
   logic [15:0]           r_hdr_req_id;
   logic [2:0]            r_hdr_tc;
   logic [1:0]            r_hdr_attr;

   logic                  w_acc;
   logic                  w_sof;
   logic                  w_eof;
   logic [31:0]           w_dw0;
   logic [31:0]           w_dw1;
   logic                  w_hdr_wr;
   logic                  w_hdr_rd;
   logic                  w_hdr_ok;
   logic                  w_tail_ok;
   logic [ADDR_WIDTH-3:0] w_beat_addr;
   logic [1:0]            w_drop_inc;

   function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Nothing is accepted while a read is pending or the link is down.
   assign w_acc       = !bus.trn_rsrc_rdy_n && !r_rd_valid && !bus.trn_lnk_up_n;
   assign w_sof       = !bus.trn_rsof_n;
   assign w_eof       = !bus.trn_reof_n;
   assign w_dw0       = bus.trn_rd[63:32];
   assign w_dw1       = bus.trn_rd[31:0];
   assign w_hdr_wr    = (w_dw0[30:24] == 7'b1000000);
   assign w_hdr_rd    = (w_dw0[30:24] == 7'b0000000);
   assign w_hdr_ok    = (w_hdr_wr || w_hdr_rd) && (w_dw0[9:0] == 10'd1) && !w_dw0[14] &&
                        !bus.trn_rbar_hit_n[BAR_INDEX] && !w_eof && bus.trn_rsrc_dsc_n;
   assign w_tail_ok   = w_eof && bus.trn_rsrc_dsc_n &&
                        (r_hdr_wr ? !bus.trn_rrem_n : bus.trn_rrem_n);
   assign w_beat_addr = bus.trn_rd[ADDR_WIDTH+31:34];

   // A SOF arriving in HDR2 drops the pending TLP and may itself be rejected: up to two drops.
   always_comb begin
      w_drop_inc = 2'd0;
      if (w_acc) begin
         case (r_state)
            S_IDLE:  if (w_sof && !w_hdr_ok) w_drop_inc = 2'd1;
            S_HDR2: begin
               if (w_sof)           w_drop_inc = w_hdr_ok ? 2'd1 : 2'd2;
               else if (!w_tail_ok) w_drop_inc = 2'd1;
            end
            default: w_drop_inc = 2'd0;
         endcase
      end
   end

   always_ff @(posedge trn_clk) begin
      if (!trn_reset_n) begin
         r_state      <= S_IDLE;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_be      <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_addr    <= '0;
         r_rd_be      <= '0;
         r_rd_tag     <= '0;
         r_rd_req_id  <= '0;
         r_rd_tc      <= '0;
         r_rd_attr    <= '0;
         r_drop_cnt   <= '0;
         r_hdr_wr     <= 1'b0;
         r_hdr_be     <= '0;
         r_hdr_tag    <= '0;
         r_hdr_req_id <= '0;
         r_hdr_tc     <= '0;
         r_hdr_attr   <= '0;
      end else begin
         r_wr_en    <= 1'b0;
         r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
         if (bus.trn_lnk_up_n) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
         end else begin
            if (r_rd_valid && bus.rd_ready) r_rd_valid <= 1'b0;
            if (w_acc) begin
               if (w_sof && r_state != S_DISCARD) begin
                  r_hdr_wr     <= w_hdr_wr;
                  r_hdr_be     <= w_dw1[3:0];
                  r_hdr_tag    <= w_dw1[15:8];
                  r_hdr_req_id <= w_dw1[31:16];
                  r_hdr_tc     <= w_dw0[22:20];
                  r_hdr_attr   <= w_dw0[13:12];
                  r_state      <= w_hdr_ok ? S_HDR2 : (w_eof ? S_IDLE : S_DISCARD);
               end else begin
                  case (r_state)
                     S_HDR2: begin
                        if (w_tail_ok) begin
                           r_state <= S_IDLE;
                           if (r_hdr_wr) begin
                              if (r_hdr_be != 4'd0) begin
                                 r_wr_en   <= 1'b1;
                                 r_wr_addr <= w_beat_addr;
                                 r_wr_data <= bus.trn_rd[31:0];
                                 r_wr_be   <= r_hdr_be;
                              end
                           end else begin
                              r_rd_valid  <= 1'b1;
                              r_rd_addr   <= w_beat_addr;
                              r_rd_be     <= r_hdr_be;
                              r_rd_tag    <= r_hdr_tag;
                              r_rd_req_id <= r_hdr_req_id;
                              r_rd_tc     <= r_hdr_tc;
                              r_rd_attr   <= r_hdr_attr;
                           end
                        end else begin
                           r_state <= w_eof ? S_IDLE : S_DISCARD;
                        end
                     end
                     S_DISCARD: if (w_eof) r_state <= S_IDLE;
                     default:   r_state <= r_state;
                  endcase
               end
            end
         end
      end
   end

   assign bus.trn_rdst_rdy_n = r_rd_valid;
   assign bus.trn_rnp_ok_n   = r_rd_valid;
   assign bus.wr_en          = r_wr_en;
   assign bus.wr_addr        = r_wr_addr;
   assign bus.wr_data        = r_wr_data;
   assign bus.wr_be          = r_wr_be;
   assign bus.rd_valid       = r_rd_valid;
   assign bus.rd_addr        = r_rd_addr;
   assign bus.rd_be          = r_rd_be;
   assign bus.rd_tag         = r_rd_tag;
   assign bus.rd_req_id      = r_rd_req_id;
   assign bus.rd_tc          = r_rd_tc;
   assign bus.rd_attr        = r_rd_attr;
   assign bus.drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_trn_rx_bar_decoder.sv
// Bench for trn_rx_bar_decoder: directed scenarios plus random TLP streams compared
// against a packet-level reference model of the decode rules.
module tb_trn_rx_bar_decoder;
   localparam int AW = 12;

   typedef struct {
      logic [31:0] dw0, dw1, dw2, data;
      logic [6:0]  hit_n;
      int          nbeats;
      logic        rrem2;
      logic        dsc0_n;
      logic        dsc2_n;
   } tlp_t;

   typedef struct packed {
      logic [AW-3:0] addr;
      logic [31:0]   data;
      logic [3:0]    be;
   } wr_t;

   typedef struct packed {
      logic [AW-3:0] addr;
      logic [3:0]    be;
      logic [7:0]    tag;
      logic [15:0]   rid;
      logic [2:0]    tc;
      logic [1:0]    attr;
   } rd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trn_rx_bar_decoder_if #(.ADDR_WIDTH(AW)) bus ();
   trn_rx_bar_decoder #(.BAR_INDEX(0), .ADDR_WIDTH(AW)) dut (
      .trn_clk     (clk),
      .trn_reset_n (rst_n),
      .bus         (bus)
   );

   wr_t exp_wr[$];
   wr_t act_wr[$];
   rd_t exp_rd[$];
   rd_t act_rd[$];
   int  act_wr_cyc[$];
   int  exp_drop;
   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   bit  rr_random = 1'b0;
   bit  rr_force = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #2;
      bus.rd_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_force;
   end

   // Output monitor: record write pulses and read handshakes, check held read fields.
   initial begin : monitor
      rd_t cur;
      rd_t prev_rd;
      bit  prev_pend;
      prev_pend = 1'b0;
      prev_rd = '0;
      forever begin
         @(negedge clk);
         cur = '{bus.rd_addr, bus.rd_be, bus.rd_tag, bus.rd_req_id, bus.rd_tc, bus.rd_attr};
         if (bus.wr_en === 1'b1) begin
            act_wr.push_back('{bus.wr_addr, bus.wr_data, bus.wr_be});
            act_wr_cyc.push_back(cyc);
         end
         if (bus.rd_valid === 1'b1 && prev_pend) begin
            n_tests++;
            if (cur !== prev_rd) begin
               n_fail++;
               $display("FAIL rd_hold: got %h required %h", cur, prev_rd);
            end
         end
         if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) act_rd.push_back(cur);
         prev_pend = (bus.rd_valid === 1'b1) && (bus.rd_ready !== 1'b1);
         prev_rd = cur;
      end
   end

   function automatic tlp_t mk(logic [31:0] dw0, logic [31:0] dw1, logic [31:0] dw2,
                               logic [31:0] data, logic [6:0] hit_n, int nbeats, logic rrem2);
      tlp_t t;
      t.dw0 = dw0; t.dw1 = dw1; t.dw2 = dw2; t.data = data;
      t.hit_n = hit_n; t.nbeats = nbeats; t.rrem2 = rrem2;
      t.dsc0_n = 1'b1; t.dsc2_n = 1'b1;
      return t;
   endfunction

   // Packet-level reference: one rejected TLP = one drop; an accepted one yields one event.
   task automatic model(input tlp_t t);
      bit is_wr, is_rd, hdr_ok, tail_ok;
      is_wr  = (t.dw0[30:29] == 2'b10) && (t.dw0[28:24] == 5'd0);
      is_rd  = (t.dw0[30:29] == 2'b00) && (t.dw0[28:24] == 5'd0);
      hdr_ok = (is_wr || is_rd) && (t.dw0[9:0] == 10'd1) && (t.dw0[14] == 1'b0) &&
               (t.hit_n[0] == 1'b0) && (t.nbeats > 1) && t.dsc0_n;
      tail_ok = (t.nbeats == 2) && t.dsc2_n && (t.rrem2 == (is_wr ? 1'b0 : 1'b1));
      if (!hdr_ok || !tail_ok) exp_drop++;
      else if (is_wr) begin
         if (t.dw1[3:0] != 4'd0) exp_wr.push_back('{t.dw2[AW-1:2], t.data, t.dw1[3:0]});
      end else
         exp_rd.push_back('{t.dw2[AW-1:2], t.dw1[3:0], t.dw1[15:8], t.dw1[31:16],
                            t.dw0[22:20], t.dw0[13:12]});
   endtask

   task automatic send_beat(input logic [63:0] d, input bit sof, input bit eof, input bit rrem_n,
                            input bit dsc_n, input logic [6:0] hit_n, input int gap);
      int n;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.trn_rd = d;
      bus.trn_rsof_n = !sof;
      bus.trn_reof_n = !eof;
      bus.trn_rrem_n = rrem_n;
      bus.trn_rsrc_dsc_n = dsc_n;
      bus.trn_rbar_hit_n = hit_n;
      bus.trn_rsrc_rdy_n = 1'b0;
      n = 0;
      while (bus.trn_rdst_rdy_n !== 1'b0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got rdst_rdy_n=%b required 0 within 300 cycles",
                  bus.trn_rdst_rdy_n);
      end
      @(posedge clk);
      #1;
      bus.trn_rsrc_rdy_n = 1'b1;
      bus.trn_rsof_n = 1'b1;
      bus.trn_reof_n = 1'b1;
      bus.trn_rsrc_dsc_n = 1'b1;
   endtask

   task automatic send_tlp(input tlp_t t, input int maxgap);
      logic [63:0] d;
      bit eof, rrem, dsc;
      for (int b = 0; b < t.nbeats; b++) begin
         eof = (b == t.nbeats - 1);
         if (b == 0)      d = {t.dw0, t.dw1};
         else if (b == 1) d = {t.dw2, t.data};
         else             d = {$urandom, $urandom};
         rrem = (eof && b == 1) ? t.rrem2 : 1'b0;
         dsc  = (b == 0) ? t.dsc0_n : ((b == 1) ? t.dsc2_n : 1'b1);
         send_beat(d, b == 0, eof, rrem, dsc, t.hit_n, $urandom_range(0, maxgap));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.trn_rsrc_rdy_n = 1'b1;
      bus.trn_lnk_up_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_wr.delete(); act_wr.delete(); exp_rd.delete(); act_rd.delete(); act_wr_cyc.delete();
      exp_drop = 0;
   endtask

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare_queues(input string name);
      n_tests++;
      if (act_wr.size() != exp_wr.size()) begin
         n_fail++;
         $display("FAIL %s_wr_count: got %0d required %0d", name, act_wr.size(), exp_wr.size());
      end else
         for (int i = 0; i < exp_wr.size(); i++) begin
            n_tests++;
            if (act_wr[i] !== exp_wr[i]) begin
               n_fail++;
               $display("FAIL %s_wr[%0d]: got %h required %h", name, i, act_wr[i], exp_wr[i]);
            end
         end
      n_tests++;
      if (act_rd.size() != exp_rd.size()) begin
         n_fail++;
         $display("FAIL %s_rd_count: got %0d required %0d", name, act_rd.size(), exp_rd.size());
      end else
         for (int i = 0; i < exp_rd.size(); i++) begin
            n_tests++;
            if (act_rd[i] !== exp_rd[i]) begin
               n_fail++;
               $display("FAIL %s_rd[%0d]: got %h required %h", name, i, act_rd[i], exp_rd[i]);
            end
         end
      n_tests++;
      if (bus.drop_cnt !== 16'(exp_drop)) begin
         n_fail++;
         $display("FAIL %s_drop_cnt: got %0d required %0d", name, bus.drop_cnt, exp_drop);
      end
   endtask

   task automatic test_reset();
      logic [73:0] outs;
      do_reset();
      outs = {bus.wr_en, bus.rd_valid, bus.drop_cnt, bus.wr_addr, bus.wr_data, bus.rd_tag,
              bus.trn_rdst_rdy_n, bus.trn_rnp_ok_n};
      n_tests++;
      if (outs !== 74'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", outs);
      end
   endtask

   task automatic test_mwr();
      tlp_t t;
      do_reset();
      t = mk(32'h4000_0001, 32'h0100_000F, 32'h0000_0124, 32'hDEAD_BEEF, 7'h7E, 2, 1'b0);
      model(t);
      send_tlp(t, 0);
      n_tests++;
      if (bus.wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL mwr_latency: got wr_en=%b required 1", bus.wr_en);
      end
      wait_clks(1);
      n_tests++;
      if (bus.wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mwr_one_cycle: got wr_en=%b required 0", bus.wr_en);
      end
      n_tests++;
      if ({bus.wr_addr, bus.wr_data, bus.wr_be} !== {10'h049, 32'hDEAD_BEEF, 4'hF}) begin
         n_fail++;
         $display("FAIL mwr_fields: got %h/%h/%h required 049/deadbeef/f",
                  bus.wr_addr, bus.wr_data, bus.wr_be);
      end
      wait_clks(2);
      compare_queues("mwr");
   endtask

   task automatic test_mrd_backpressure();
      tlp_t t;
      do_reset();
      rr_random = 1'b0;
      rr_force = 1'b0;
      t = mk(32'h0000_0001, 32'hABCD_2A0F, 32'h0000_0008, 32'h0, 7'h7E, 2, 1'b1);
      model(t);
      send_tlp(t, 0);
      n_tests++;
      if ({bus.rd_tag, bus.rd_req_id, bus.rd_addr, bus.rd_be} !== {8'h2A, 16'hABCD, 10'h002, 4'hF}) begin
         n_fail++;
         $display("FAIL mrd_fields: got tag=%h id=%h addr=%h be=%h required 2a/abcd/002/f",
                  bus.rd_tag, bus.rd_req_id, bus.rd_addr, bus.rd_be);
      end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if ({bus.rd_valid, bus.trn_rdst_rdy_n, bus.trn_rnp_ok_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL mrd_hold[%0d]: got valid/rdst/rnp=%b required 111", i,
                     {bus.rd_valid, bus.trn_rdst_rdy_n, bus.trn_rnp_ok_n});
         end
         wait_clks(1);
      end
      rr_force = 1'b1;
      wait_clks(1);
      rr_force = 1'b0;
      n_tests++;
      if ({bus.rd_valid, bus.trn_rdst_rdy_n, bus.trn_rnp_ok_n} !== 3'b000) begin
         n_fail++;
         $display("FAIL mrd_release: got valid/rdst/rnp=%b required 000",
                  {bus.rd_valid, bus.trn_rdst_rdy_n, bus.trn_rnp_ok_n});
      end
      wait_clks(2);
      compare_queues("mrd");
   endtask

   task automatic test_rejected();
      tlp_t t[4];
      do_reset();
      t[0] = mk(32'h4000_0001, 32'h0100_000F, 32'h10, 32'h1, 7'h7D, 2, 1'b0);
      t[1] = mk(32'h4000_0002, 32'h0100_000F, 32'h10, 32'h2, 7'h7E, 3, 1'b0);
      t[2] = mk(32'h4000_4001, 32'h0100_000F, 32'h10, 32'h3, 7'h7E, 2, 1'b0);
      t[3] = mk(32'h6000_0001, 32'h0100_000F, 32'h0, 32'h10, 7'h7E, 3, 1'b0);
      foreach (t[i]) begin
         model(t[i]);
         send_tlp(t[i], 1);
      end
      wait_clks(2);
      compare_queues("rejected");
      n_tests++;
      if (bus.drop_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL rejected_four: got %0d required 4", bus.drop_cnt);
      end
   endtask

   task automatic test_discontinue();
      tlp_t t;
      do_reset();
      t = mk(32'h4000_0001, 32'h0100_000F, 32'h0000_0124, 32'hDEAD_BEEF, 7'h7E, 2, 1'b0);
      t.dsc2_n = 1'b0;
      model(t);
      send_tlp(t, 0);
      t = mk(32'h4000_0001, 32'h0100_0003, 32'h0000_03FC, 32'h1234_5678, 7'h7E, 2, 1'b0);
      model(t);
      send_tlp(t, 0);
      wait_clks(2);
      compare_queues("discontinue");
   endtask

   task automatic test_flush();
      tlp_t t;
      do_reset();
      rr_random = 1'b0;
      rr_force = 1'b0;
      t = mk(32'h4000_0001, 32'h0100_000F, 32'h10, 32'h1, 7'h7D, 2, 1'b0);
      model(t);
      send_tlp(t, 0);
      t = mk(32'h0000_0001, 32'h5555_1102, 32'h40, 32'h0, 7'h7E, 2, 1'b1);
      send_tlp(t, 0);
      bus.trn_lnk_up_n = 1'b1;
      wait_clks(1);
      bus.trn_lnk_up_n = 1'b0;
      n_tests++;
      if ({bus.rd_valid, bus.trn_rdst_rdy_n, bus.drop_cnt} !== {2'b00, 16'd1}) begin
         n_fail++;
         $display("FAIL flush_link: got valid=%b rdst=%b drop=%0d required 0/0/1",
                  bus.rd_valid, bus.trn_rdst_rdy_n, bus.drop_cnt);
      end
      t = mk(32'h4000_0001, 32'h0100_0009, 32'h0000_0F00, 32'hCAFE_0001, 7'h7E, 2, 1'b0);
      model(t);
      send_tlp(t, 0);
      send_beat({32'h4000_0001, 32'h0100_000F}, 1'b1, 1'b0, 1'b0, 1'b1, 7'h7E, 0);
      rst_n = 1'b0;
      wait_clks(1);
      rst_n = 1'b1;
      exp_drop = 0;
      n_tests++;
      if ({bus.rd_valid, bus.wr_en, bus.drop_cnt} !== 18'd0) begin
         n_fail++;
         $display("FAIL flush_reset: got valid=%b wr_en=%b drop=%0d required 0/0/0",
                  bus.rd_valid, bus.wr_en, bus.drop_cnt);
      end
      send_beat({32'h0000_0080, 32'hBAD0_BAD0}, 1'b0, 1'b1, 1'b0, 1'b1, 7'h7E, 0);
      t = mk(32'h4000_0001, 32'h0100_000C, 32'h0000_0004, 32'hCAFE_0002, 7'h7E, 2, 1'b0);
      model(t);
      send_tlp(t, 0);
      wait_clks(2);
      compare_queues("flush");
   endtask

   task automatic test_back_to_back();
      tlp_t t;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         t = mk(32'h4000_0001, 32'h0100_0000 | 32'(i + 1), 32'(i * 8), $urandom, 7'h7E, 2, 1'b0);
         model(t);
         send_tlp(t, 0);
      end
      wait_clks(2);
      compare_queues("b2b");
      for (int i = 1; i < act_wr_cyc.size(); i++) begin
         n_tests++;
         if (act_wr_cyc[i] - act_wr_cyc[i-1] != 2) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles required 2", i,
                     act_wr_cyc[i] - act_wr_cyc[i-1]);
         end
      end
   endtask

   function automatic tlp_t gen();
      tlp_t t;
      bit   is_wr;
      is_wr = 1'($urandom_range(0, 1));
      t = mk((is_wr ? 32'h4000_0001 : 32'h0000_0001) | ($urandom & 32'h0070_3000),
             $urandom, $urandom, $urandom, {6'($urandom), 1'b0}, 2, is_wr ? 1'b0 : 1'b1);
      case ($urandom_range(0, 13))
         0:  t.hit_n[0] = 1'b1;
         1:  t.dw0[9:0] = 10'd2;
         2:  t.dw0[14] = 1'b1;
         3:  t.dw0[29] = 1'b1;
         4:  t.dw0[24] = 1'b1;
         5:  t.nbeats = 1;
         6:  t.nbeats = 3;
         7:  t.rrem2 = ~t.rrem2;
         8:  t.dsc2_n = 1'b0;
         9:  t.dw1[3:0] = 4'd0;
         10: t.dsc0_n = 1'b0;
         default: ;
      endcase
      return t;
   endfunction

   task automatic test_random();
      tlp_t t;
      int   n;
      do_reset();
      rr_random = 1'b1;
      for (int i = 0; i < 120; i++) begin
         t = gen();
         model(t);
         send_tlp(t, 2);
      end
      n = 0;
      while (bus.rd_valid === 1'b1 && n < 200) begin
         wait_clks(1);
         n++;
      end
      wait_clks(3);
      compare_queues("random");
      rr_random = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 65535; i++)
         send_beat({32'h4000_0001, 32'h0100_000F}, 1'b1, 1'b1, 1'b0, 1'b1, 7'h7E, 0);
      n_tests++;
      if (bus.drop_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_reach: got %h required ffff", bus.drop_cnt);
      end
      repeat (2) send_beat({32'h0000_0002, 32'h0}, 1'b1, 1'b1, 1'b0, 1'b1, 7'h7E, 0);
      n_tests++;
      if (bus.drop_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_hold: got %h required ffff", bus.drop_cnt);
      end
   endtask

   initial begin
      bus.trn_lnk_up_n = 1'b0;
      bus.trn_rd = '0;
      bus.trn_rrem_n = 1'b0;
      bus.trn_rsof_n = 1'b1;
      bus.trn_reof_n = 1'b1;
      bus.trn_rsrc_rdy_n = 1'b1;
      bus.trn_rsrc_dsc_n = 1'b1;
      bus.trn_rbar_hit_n = 7'h7F;
      bus.rd_ready = 1'b0;
      test_reset();
      test_mwr();
      test_mrd_backpressure();
      test_rejected();
      test_discontinue();
      test_flush();
      test_back_to_back();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/trn_rx_bar_decoder.md
Name: trn_rx_bar_decoder

Overview:
- Consumes the 64-bit TRN receive stream from the PCIe endpoint wrapper, on the TRN clock domain.
- Decodes single-DW 32-bit Memory Write (MWr32) and Memory Read (MRd32) TLPs that hit one selected BAR.
- Each MWr32 becomes a one-cycle register-write strobe.
- Each MRd32 becomes a held read request (valid/ready) for the downstream completion generator.
- Every other TLP is consumed, discarded and counted.

Parameters:
- BAR_INDEX, 0, index into trn_rbar_hit_n of the BAR decoded by this block.
- ADDR_WIDTH, 12, byte-offset width inside the BAR; wr_addr/rd_addr carry bits [ADDR_WIDTH-1:2].

Ports:
- trn_clk  in  1  TRN clock.
- trn_reset_n  in  1  synchronous active-low reset.
- trn_lnk_up_n  in  1  link down when 1.
- trn_rd  in  64  Rx data; [63:32] is the earlier DW.
- trn_rrem_n  in  1  0 = both DWs valid; 1 = only [63:32] valid (EOF beat only).
- trn_rsof_n  in  1  start of TLP.
- trn_reof_n  in  1  end of TLP.
- trn_rsrc_rdy_n  in  1  source beat valid.
- trn_rsrc_dsc_n  in  1  source discontinue.
- trn_rbar_hit_n  in  7  BAR hit vector, valid on SOF beat.
- trn_rdst_rdy_n  out  1  destination ready.
- trn_rnp_ok_n  out  1  non-posted acceptance.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_WIDTH-2  DW address.
- wr_data  out  32  payload DW as received, no byte swap.
- wr_be  out  4  first-DW byte enables.
- rd_valid  out  1  read request pending.
- rd_ready  in  1  read request taken.
- rd_addr  out  ADDR_WIDTH-2  DW address.
- rd_be  out  4  first-DW byte enables.
- rd_tag  out  8  TLP tag.
- rd_req_id  out  16  requester ID.
- rd_tc  out  3  traffic class.
- rd_attr  out  2  attributes.
- drop_cnt  out  16  saturating count of discarded TLPs.

Behaviour:
- Clock and reset: single clock trn_clk; reset trn_reset_n is synchronous, active-low.
- Reset values: state IDLE; wr_en 0; rd_valid 0; drop_cnt 0; all address/data/ID outputs 0.
- Link down: trn_lnk_up_n=1 acts as a synchronous flush. State goes to IDLE and rd_valid clears; drop_cnt is kept.
- Ready outputs:
  - trn_rdst_rdy_n = rd_valid.
  - trn_rnp_ok_n = rd_valid.
  - Both come straight from the registered flag, so nothing is accepted while a read is pending.
- Beat acceptance: a beat is accepted when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0.
- Header fields:
  - DW0: fmt [30:29], type [28:24], TC [22:20], EP [14], attr [13:12], length [9:0].
  - DW1: requester ID [31:16], tag [15:8], first BE [3:0].
  - DW2: address.
- States:
  - IDLE
    - On an accepted SOF beat, latch DW0/DW1 and the BAR hit.
    - Go to HDR2 if all hold: fmt/type is 10/00000 (MWr32) or 00/00000 (MRd32); length==1; EP==0; trn_rbar_hit_n[BAR_INDEX]==0; trn_reof_n==1; trn_rsrc_dsc_n==1.
    - Otherwise go to DISCARD, or stay in IDLE with drop_cnt+1 if the beat is also EOF.
    - A non-SOF beat in IDLE is ignored and not counted.
  - HDR2: acts on the next accepted beat.
    - MWr32 requires EOF with trn_rrem_n=0. Next cycle: wr_en=1 for exactly one cycle; wr_addr=[ADDR_WIDTH-1+32:34]; wr_data=[31:0]; wr_be=first BE.
    - MRd32 requires EOF with trn_rrem_n=1. Next cycle: rd_valid=1 with all rd_* fields latched.
    - Either case returns to IDLE.
    - Missing EOF, wrong rrem or dsc=0: drop_cnt+1; go to DISCARD if not EOF, else IDLE.
    - A SOF while in HDR2 is treated as a new header (previous TLP counted dropped).
  - DISCARD: consume beats until accepted EOF, then IDLE.
- Zero-BE write: MWr32 with first BE=0 produces no wr_en and no drop count.
- Read handshake:
  - rd_valid and rd_* are held stable until a cycle with rd_valid=1 and rd_ready=1.
  - rd_valid is 0 on the next cycle, and beats are accepted again from that cycle.
- drop_cnt saturates at 0xFFFF.
- Latency: accepted final beat at cycle t gives wr_en or rd_valid at t+1. Back-to-back MWr32 sustain 1 write per 2 cycles.

Test Plan:
- MWr32 write:
  - Stimulus: hit BAR0; DW0=0x40000001, DW1=0x0100000F, addr 0x00000124, data 0xDEADBEEF, rrem_n=0.
  - Response: single wr_en pulse with wr_addr=0x049, wr_data=0xDEADBEEF, wr_be=0xF; drop_cnt=0.
- MRd32 read with backpressure:
  - Stimulus: DW0=0x00000001, DW1=0xABCD2A0F, addr 0x8; rd_ready held 0 for 5 cycles.
  - Response:
    - rd_valid=1 with rd_tag=0x2A, rd_req_id=0xABCD, rd_addr=0x002.
    - trn_rdst_rdy_n and trn_rnp_ok_n=1 throughout.
    - After the handshake, both are 0 on the next cycle.
- Rejected TLPs (BAR1 hit, length=2 MWr, EP=1, MWr64 fmt=11):
  - Response: no wr_en/rd_valid; all beats consumed; drop_cnt=4.
- Discontinue:
  - Stimulus: MWr32 header, then beat 2 with trn_rsrc_dsc_n=0 and EOF.
  - Response: no wr_en; drop_cnt +1; next valid MWr32 is decoded normally.
- Flush:
  - Stimulus: rd_valid pending, then trn_lnk_up_n=1 for one cycle; separately, trn_reset_n=0 mid-TLP.
  - Response: rd_valid=0 and state IDLE next cycle; reset also clears drop_cnt to 0.
- Saturation:
  - Stimulus: preload via 65537 rejected TLPs (or force).
  - Response: drop_cnt stays 0xFFFF.
